packet_collector: RTL and testbench

- Downstream stage of the 4/7-2 packet-boundary detector in `top`.
- Consumes the detector's begP/endP pulses and the same serial dataIn stream.
- Between begP and endP, deserializes payload bits MSB-first into bytes and presents them on a valid/ready byte interface.
- On packet close, reports byte count, residual bit count and an error flag.

---
 rtl/pkt_pkg.sv | 13 +
 rtl/bit_deserializer.sv | 46 ++++
 rtl/packet_collector.sv | 165 ++++++++++++++++
 tb/tb_packet_collector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet collector: FSM state encoding and byte width.
package pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2,
    DONE    = 2'd3
  } coll_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/bit_deserializer.sv
// MSB-first serial-to-byte shifter. byte_o/byte_done describe the byte that the
// current edge would complete, so the consumer can capture it on that same edge.
module bit_deserializer
  import pkt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              din,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_done,
  output logic [2:0]        cnt_o
);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]        cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[BYTE_W-2:0], din};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // The eighth bit wraps the counter back to zero; that bit completes the byte.
  assign byte_o    = {shreg_q[BYTE_W-2:0], din};
  assign byte_done = shift_en && !clr && (cnt_q == 3'd7);
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/packet_collector.sv
// Collects payload bits between begP and endP into bytes on a valid/ready port and
// reports per-packet length, residual bits and error status when the packet closes.
module packet_collector
  import pkt_pkg::*;
#(
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dataIn,
  input  logic              begP,
  input  logic              endP,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [2:0]        pkt_tail,
  output coll_state_t       state_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  coll_state_t       state_q, state_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0] byte_data_q, byte_data_d;
  logic              byte_valid_q, byte_valid_d;
  logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
  logic [2:0]        pkt_tail_q, pkt_tail_d;
  logic              pkt_err_q, pkt_err_d;
  logic              restart_q, restart_d;

  logic              shift_en;
  logic              des_clr;
  logic [BYTE_W-1:0] des_byte;
  logic              des_done;
  logic [2:0]        des_cnt;

  bit_deserializer u_des (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .clr       (des_clr),
    .din       (dataIn),
    .byte_o    (des_byte),
    .byte_done (des_done),
    .cnt_o     (des_cnt)
  );

  // Byte port: a transfer happens on every edge where byte_valid && byte_ready.
  // byte_data is held stable while byte_valid=1 and byte_ready=0; a byte loaded on
  // the same edge as a transfer keeps byte_valid high with the new data.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q && !byte_ready;
    pkt_len_d    = pkt_len_q;
    pkt_tail_d   = pkt_tail_q;
    pkt_err_d    = pkt_err_q;
    restart_d    = restart_q;
    shift_en     = 1'b0;
    des_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        des_clr = 1'b1;
        if (begP && !endP) begin
          state_d    = COLLECT;
          byte_cnt_d = '0;
          pkt_len_d  = '0;
          pkt_tail_d = '0;
          pkt_err_d  = 1'b0;
        end
      end

      COLLECT: begin
        if (endP) begin
          state_d    = DONE;
          pkt_len_d  = byte_cnt_q;
          pkt_tail_d = des_cnt;
          pkt_err_d  = 1'b0;
          restart_d  = 1'b0;
        end else if (begP) begin
          state_d    = DONE;
          pkt_len_d  = byte_cnt_q;
          pkt_tail_d = des_cnt;
          pkt_err_d  = 1'b1;
          restart_d  = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (des_done) begin
            // Overflow or overrun: the new byte is dropped and the rest of the packet ignored.
            if ((byte_cnt_q == MAX_LEN) || (byte_valid_q && !byte_ready)) begin
              state_d = DROP;
            end else begin
              byte_data_d  = des_byte;
              byte_valid_d = 1'b1;
              byte_cnt_d   = byte_cnt_q + LEN_W'(1);
            end
          end
        end
      end

      DROP: begin
        if (endP || begP) begin
          state_d    = DONE;
          pkt_len_d  = byte_cnt_q;
          pkt_tail_d = des_cnt;
          pkt_err_d  = 1'b1;
          restart_d  = !endP;
        end
      end

      DONE: begin
        des_clr   = 1'b1;
        restart_d = 1'b0;
        if (restart_q || (begP && !endP)) begin
          state_d    = COLLECT;
          byte_cnt_d = '0;
          pkt_len_d  = '0;
          pkt_tail_d = '0;
          pkt_err_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      pkt_len_q    <= '0;
      pkt_tail_q   <= '0;
      pkt_err_q    <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      pkt_len_q    <= pkt_len_d;
      pkt_tail_q   <= pkt_tail_d;
      pkt_err_q    <= pkt_err_d;
      restart_q    <= restart_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign pkt_done   = (state_q == DONE);
  assign pkt_err    = pkt_err_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_tail   = pkt_tail_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_packet_collector.sv
// Bench for packet_collector: directed scenarios plus random packets, scored against
// a bit-list model of how payload bits group into bytes and packet status.
module tb_packet_collector;
  import pkt_pkg::*;

  localparam int MAX_BYTES = 16;
  localparam int LEN_W     = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              dataIn, begP, endP, byte_ready;
  logic [7:0]        byte_data;
  logic              byte_valid, pkt_done, pkt_err;
  logic [LEN_W-1:0]  pkt_len;
  logic [2:0]        pkt_tail;
  coll_state_t       state_o;

  packet_collector #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .dataIn     (dataIn),
    .begP       (begP),
    .endP       (endP),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .pkt_len    (pkt_len),
    .pkt_tail   (pkt_tail),
    .state_o    (state_o)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       pkt_bits[$];
  int         done_cnt = 0;
  logic [LEN_W-1:0] cap_len;
  logic [2:0]       cap_tail;
  logic             cap_err;
  int         exp_len, exp_tail;
  logic       exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record any byte transfer on this edge and any pkt_done after it.
  task automatic step();
    logic       hs;
    logic [7:0] hd;
    hs = byte_valid && byte_ready;
    hd = byte_data;
    @(posedge clk);
    #1;
    if (hs) got_q.push_back(hd);
    if (pkt_done) begin
      done_cnt++;
      cap_len  = pkt_len;
      cap_tail = pkt_tail;
      cap_err  = pkt_err;
    end
  endtask

  // driver tasks
  task automatic drive(input logic b, input logic bp, input logic ep);
    dataIn = b;
    begP   = bp;
    endP   = ep;
    step();
    begP   = 1'b0;
    endP   = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) pkt_bits.push_back(v[i]);
  endtask

  task automatic send_bits();
    foreach (pkt_bits[i]) drive(pkt_bits[i], 1'b0, 1'b0);
  endtask

  // Reference: whole groups of 8 bits are bytes (first bit is MSB); at most
  // MAX_BYTES are delivered, a further byte marks the packet as errored.
  task automatic model();
    int nbytes;
    exp_q.delete();
    nbytes = pkt_bits.size() / 8;
    for (int k = 0; k < nbytes && k < MAX_BYTES; k++) begin
      logic [7:0] v;
      for (int j = 0; j < 8; j++) v[7-j] = pkt_bits[8*k+j];
      exp_q.push_back(v);
    end
    if (nbytes > MAX_BYTES) begin
      exp_err  = 1'b1;
      exp_len  = MAX_BYTES;
      exp_tail = 0;
    end else begin
      exp_err  = 1'b0;
      exp_len  = nbytes;
      exp_tail = pkt_bits.size() % 8;
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_len"}, cap_len, exp_len);
    check({tag, "_tail"}, cap_tail, exp_tail);
    check({tag, "_err"}, cap_err, exp_err);
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    check({tag, "_len_hold"}, pkt_len, exp_len);
  endtask

  // Runs pkt_bits as one packet with byte_ready=1; both_pulses closes with begP&endP.
  task automatic run_packet(input string tag, input logic both_pulses);
    got_q.delete();
    done_cnt   = 0;
    byte_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    send_bits();
    drive(1'($urandom_range(0, 1)), both_pulses, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    model();
    verify(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; dataIn = 1'b0; begP = 1'b1; endP = 1'b0; byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", byte_valid, 1'b0);
    check("rst_data", byte_data, 8'h00);
    check("rst_done", pkt_done, 1'b0);
    check("rst_len", pkt_len, 0);
    check("rst_tail", pkt_tail, 0);
    check("rst_err", pkt_err, 1'b0);
    check("rst_state", state_o, IDLE);
    reset = 1'b1;
    begP  = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("rst_no_done", done_cnt, 0);

    // begP and endP together in IDLE are both ignored
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("idle_both_state", state_o, IDLE);
    check("idle_both_done", done_cnt, 0);

    pkt_bits.delete(); push_byte(8'hA5); push_byte(8'h3C);
    run_packet("normal", 1'b0);

    pkt_bits.delete(); push_byte(8'hB1);
    pkt_bits.push_back(1'b1); pkt_bits.push_back(1'b1); pkt_bits.push_back(1'b0);
    run_packet("tail", 1'b0);

    // begP with endP in COLLECT: normal close
    pkt_bits.delete(); push_byte(8'($urandom)); pkt_bits.push_back(1'b1);
    run_packet("both_collect", 1'b1);

    // overrun: consumer stalls, second byte is lost
    got_q.delete(); done_cnt = 0; byte_ready = 1'b0;
    pkt_bits.delete(); push_byte(8'hFF); push_byte(8'h00);
    drive(1'b0, 1'b1, 1'b0);
    send_bits();
    check("ovr_data_hold", byte_data, 8'hFF);
    check("ovr_valid_hold", byte_valid, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    check("ovr_done", done_cnt, 1);
    check("ovr_err", cap_err, 1'b1);
    check("ovr_len", cap_len, 1);
    check("ovr_valid_after", byte_valid, 1'b1);
    check("ovr_data_after", byte_data, 8'hFF);
    byte_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("ovr_valid_clear", byte_valid, 1'b0);
    check("ovr_nbytes", got_q.size(), 1);
    if (got_q.size() > 0) check("ovr_byte", got_q.pop_front(), 8'hFF);

    // overflow: one byte beyond the limit
    pkt_bits.delete();
    for (int k = 0; k <= MAX_BYTES; k++) push_byte(8'($urandom));
    run_packet("overflow", 1'b0);

    // abort after 5 bits, then a fresh 0x5A packet
    got_q.delete(); done_cnt = 0; byte_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    check("abort_done", done_cnt, 1);
    check("abort_err", cap_err, 1'b1);
    check("abort_len", cap_len, 0);
    check("abort_tail", cap_tail, 5);
    drive(1'b1, 1'b0, 1'b0);
    got_q.delete(); done_cnt = 0;
    pkt_bits.delete(); push_byte(8'h5A);
    send_bits();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    model();
    verify("restart");

    // random packets, some long enough to overflow
    for (int r = 0; r < 6; r++) begin
      int nbits;
      nbits = $urandom_range(0, 150);
      pkt_bits.delete();
      for (int i = 0; i < nbits; i++) pkt_bits.push_back(1'($urandom_range(0, 1)));
      run_packet($sformatf("rand%0d", r), 1'b0);
    end

    // reset mid-packet with a pending byte
    byte_ready = 1'b0;
    pkt_bits.delete(); push_byte(8'($urandom)); pkt_bits.push_back(1'b1);
    drive(1'b0, 1'b1, 1'b0);
    send_bits();
    check("mid_valid_pre", byte_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_valid", byte_valid, 1'b0);
    check("mid_data", byte_data, 8'h00);
    check("mid_len", pkt_len, 0);
    check("mid_err", pkt_err, 1'b0);
    check("mid_state", state_o, IDLE);
    @(posedge clk);
    #1;
    reset = 1'b1;
    byte_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
